riscv_apb_bridge: RTL and testbench
===================================

// Module: riscv_apb_bridge
// PURPOSE
//   Sequences MEM-stage load/store accesses in the peripheral window onto an APB3 bus (UART etc.).
//   Drives uart_stall into the hazard unit, which freezes the whole pipeline while a transfer is open.
//   Returns read data and slave error to MEM/WB in the single release cycle.
// PARAMETERS
//   PERIPH_BASE    32'h4000_0000  peripheral window base; hit = (mem_addr & PERIPH_MASK) == PERIPH_BASE
//   PERIPH_MASK    32'hF000_0000  window decode mask
//   TIMEOUT_CYCLES 255            ACCESS-phase watchdog limit (only with APB_TIMEOUT_EN); 8-bit counter
// PORTS
//   clk         in   1   core clock, rising edge
//   rst         in   1   synchronous, active-high reset
//   mem_req     in   1   MEM stage holds a valid load/store
//   mem_we      in   1   1 = store, 0 = load
//   mem_addr    in   32  byte address
//   mem_wdata   in   32  store data
//   mem_wstrb   in   4   store byte enables
//   mem_rdata   out  32  load result; valid in DONE cycle only
//   mem_err     out  1   PSLVERR/timeout flag; valid in DONE cycle only
//   uart_stall  out  1   freeze request to hazard unit (combinational)
//   paddr       out  32  APB address
//   psel        out  1   APB select
//   penable     out  1   APB enable
//   pwrite      out  1   APB direction
//   pwdata      out  32  APB write data
//   pstrb       out  4   APB write strobes (forced 4'b0000 on reads)
//   prdata      in   32  APB read data
//   pready      in   1   APB ready
//   pslverr     in   1   APB slave error
// BEHAVIOUR
//   - FSM states: IDLE, SETUP, ACCESS, DONE. Reset -> IDLE; psel=penable=pwrite=0, paddr=pwdata=0,
//     pstrb=0, mem_rdata=0, mem_err=0, uart_stall=0 (IDLE with no hit), timeout counter=0.
//   - hit = mem_req & window match. Not hit: block is transparent, uart_stall=0.
//   - IDLE & hit: uart_stall=1 combinationally; register paddr/pwrite/pwdata/pstrb from mem_*; -> SETUP.
//   - SETUP: psel=1, penable=0, uart_stall=1; -> ACCESS unconditionally.
//   - ACCESS: psel=1, penable=1, uart_stall=1. pready=1: capture prdata->mem_rdata (reads only;
//     stores leave mem_rdata unchanged), pslverr->mem_err; drop psel/penable; -> DONE. pready=0: hold all.
//   - DONE: uart_stall=0, psel=penable=0; pipeline advances on this edge; hit ignored (request is the
//     same still-held instruction); -> IDLE. mem_err cleared on leaving DONE.
//   - Minimum stall: 3 cycles (IDLE-hit, SETUP, ACCESS) + 1 per pready=0 cycle.
//   - Back-to-back peripheral accesses: next instruction reaches MEM after DONE; restart from IDLE, no gap
//     beyond the DONE cycle.
//   - APB outputs stable from SETUP through ACCESS completion regardless of mem_* changes.
//   - mem_req dropping mid-transfer (flush) is ignored; transfer completes (APB forbids abort).
//   - rst in any state: next edge -> IDLE, psel/penable=0, uart_stall=0; in-flight transfer abandoned.
// CONFIGURATION
//   APB_TIMEOUT_EN defined: counter increments each ACCESS cycle with pready=0; when it reaches
//     TIMEOUT_CYCLES, terminate as if pready=1 with pslverr=1, mem_rdata=32'hDEAD_BEEF (reads); -> DONE.
//     Counter cleared on entry to SETUP.
//   APB_TIMEOUT_EN undefined: no counter; ACCESS waits for pready indefinitely.
// TESTING
//   1. Load 0x4000_0004, pready=1 first ACCESS, prdata=0x0000_00A5 -> uart_stall high exactly 3 cycles,
//      mem_rdata=0xA5, mem_err=0 in DONE.
//   2. Store 0x4000_0000 wdata=0x41 wstrb=4'b0001, pready low 2 cycles -> stall 5 cycles; pwrite=1,
//      pwdata=0x41, pstrb=0001 held stable SETUP..ACCESS end.
//   3. Load 0x0000_1000 (outside window) -> psel never asserts, uart_stall stays 0.
//   4. Load with pslverr=1 on completing cycle -> mem_err=1 for DONE cycle only, 0 next cycle.
//   5. rst pulsed during ACCESS with pready=0 -> next cycle IDLE, psel=penable=uart_stall=0.
//   6. APB_TIMEOUT_EN, TIMEOUT_CYCLES=4, pready stuck 0 -> DONE after 4 ACCESS cycles,
//      mem_err=1, mem_rdata=0xDEAD_BEEF.

Source files
------------

// File: rtl/riscv_apb_bridge.sv
// MEM-stage to APB3 bridge: freezes the pipeline via uart_stall while a peripheral transfer is open.
// Optional ACCESS-phase watchdog is compiled in with `define APB_TIMEOUT_EN.
module riscv_apb_bridge #(
  parameter logic [31:0] PERIPH_BASE    = 32'h4000_0000,
  parameter logic [31:0] PERIPH_MASK    = 32'hF000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_err,
  output logic        uart_stall,
  output logic [31:0] paddr,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] pwdata,
  output logic [3:0]  pstrb,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // The watchdog counter is 8 bits wide, so the limit must fit in it.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("riscv_apb_bridge: TIMEOUT_CYCLES must be in 1..255");
  end

  state_t      r_state;
  state_t      w_next;
  logic        w_hit;
  logic        w_launch;
  logic        w_complete;
  logic        w_tmo_hit;
  logic [31:0] r_paddr;
  logic [31:0] r_pwdata;
  logic [3:0]  r_pstrb;
  logic        r_pwrite;
  logic [31:0] r_rdata;
  logic        r_err;

  assign w_hit = mem_req & ((mem_addr & PERIPH_MASK) == PERIPH_BASE);

`ifdef APB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_tmo;

  // Fires on the ACCESS cycle that would be the TIMEOUT_CYCLES-th wait.
  assign w_tmo_hit = (r_state == ST_ACCESS) && !pready && (r_tmo == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo <= 8'd0;
    end else if (w_launch) begin
      r_tmo <= 8'd0;
    end else if ((r_state == ST_ACCESS) && !pready) begin
      r_tmo <= r_tmo + 8'd1;
    end
  end
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // DONE is the single release cycle; a still-held request there is the same instruction.
  always_comb begin
    w_next     = r_state;
    uart_stall = 1'b0;
    psel       = 1'b0;
    penable    = 1'b0;
    w_launch   = 1'b0;
    w_complete = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_hit) begin
          uart_stall = 1'b1;
          w_launch   = 1'b1;
          w_next     = ST_SETUP;
        end
      end
      ST_SETUP: begin
        uart_stall = 1'b1;
        psel       = 1'b1;
        w_next     = ST_ACCESS;
      end
      ST_ACCESS: begin
        uart_stall = 1'b1;
        psel       = 1'b1;
        penable    = 1'b1;
        if (pready || w_tmo_hit) begin
          w_complete = 1'b1;
          w_next     = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_paddr  <= 32'd0;
      r_pwdata <= 32'd0;
      r_pstrb  <= 4'd0;
      r_pwrite <= 1'b0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      // APB request fields are frozen at launch so later mem_* changes cannot disturb them.
      if (w_launch) begin
        r_paddr  <= mem_addr;
        r_pwrite <= mem_we;
        r_pwdata <= mem_wdata;
        r_pstrb  <= mem_we ? mem_wstrb : 4'b0000;
      end
      if (w_complete) begin
        r_err <= pready ? pslverr : 1'b1;
        if (!r_pwrite) begin
          r_rdata <= pready ? prdata : 32'hDEAD_BEEF;
        end
      end else if (r_state == ST_DONE) begin
        r_err <= 1'b0;
      end
    end
  end

  assign paddr     = r_paddr;
  assign pwrite    = r_pwrite;
  assign pwdata    = r_pwdata;
  assign pstrb     = r_pstrb;
  assign mem_rdata = r_rdata;
  assign mem_err   = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_riscv_apb_bridge.sv
// Self-checking bench for riscv_apb_bridge: directed cases plus randomized transfers against a
// transaction-level model (stall length, returned data, error flag, APB field stability).
module tb_riscv_apb_bridge;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] MASK = 32'hF000_0000;
`ifdef APB_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 0;
`endif
  localparam int unsigned DUT_TMO = (TMO == 0) ? 255 : TMO;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic        uart_stall;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [1:0]  dbg_state;

  riscv_apb_bridge #(
    .PERIPH_BASE   (BASE),
    .PERIPH_MASK   (MASK),
    .TIMEOUT_CYCLES(DUT_TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .mem_err   (mem_err),
    .uart_stall(uart_stall),
    .paddr     (paddr),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .pstrb     (pstrb),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr),
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_rdata = 32'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // Drives one MEM-stage access and plays the APB slave with `waits` not-ready ACCESS cycles.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input int waits, input logic [31:0] rd,
                        input logic serr, input logic scramble);
    logic        hit;
    logic        tmo;
    logic        exp_err;
    logic        in_acc;
    logic        done;
    logic [31:0] prev_rdata;
    logic [31:0] exp_rd;
    int          exp_stall;
    int          stall;
    int          wl;

    hit        = ((addr & MASK) == BASE);
    tmo        = (TMO != 0) && (waits >= TMO);
    exp_stall  = hit ? (2 + (tmo ? TMO : waits + 1)) : 0;
    exp_err    = tmo ? 1'b1 : serr;
    prev_rdata = model_rdata;
    if (hit && !we) model_rdata = tmo ? 32'hDEAD_BEEF : rd;
    if (hit) exp_q.push_back(model_rdata);

    @(negedge clk);
    mem_req   = 1'b1;
    mem_we    = we;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    prdata    = rd;
    pslverr   = serr;
    pready    = 1'b0;
    wl        = waits;
    stall     = 0;
    in_acc    = 1'b0;
    done      = 1'b0;

    #1;
    chk1("idle_err_clear", mem_err, 1'b0);
    chk("idle_rdata_held", mem_rdata, prev_rdata);
    chk1("stall_on_first", uart_stall, hit);

    if (!hit) begin
      for (int c = 0; c < 3; c++) begin
        if (c > 0) begin
          @(negedge clk);
          #1;
        end
        chk1("miss_psel", psel, 1'b0);
        chk1("miss_stall", uart_stall, 1'b0);
      end
    end else begin
      for (int c = 0; c < 400 && !done; c++) begin
        if (c > 0) begin
          @(negedge clk);
          #1;
        end
        if (in_acc && !psel) begin
          chk("done_rdata", mem_rdata, exp_q.pop_front());
          chk1("done_err", mem_err, exp_err);
          chk1("done_stall", uart_stall, 1'b0);
          chk1("done_penable", penable, 1'b0);
          done = 1'b1;
        end else begin
          if (uart_stall) stall++;
          if (psel) begin
            chk("paddr", paddr, addr);
            chk1("pwrite", pwrite, we);
            if (we) chk("pwdata", pwdata, wdata);
            chk("pstrb", 32'(pstrb), we ? 32'(wstrb) : 32'd0);
          end
          if (psel && penable) begin
            in_acc = 1'b1;
            pready = (wl == 0);
            if (wl > 0) wl--;
          end else begin
            pready = 1'b0;
          end
          if (scramble && c > 0) begin
            mem_req   = 1'($urandom_range(1, 0));
            mem_we    = 1'($urandom_range(1, 0));
            mem_addr  = $urandom;
            mem_wdata = $urandom;
            mem_wstrb = 4'($urandom);
          end
        end
      end
      chk1("done_reached", done, 1'b1);
      chk("stall_cycles", 32'(stall), 32'(exp_stall));
      pready = 1'b0;
    end
  endtask

  // Asserts reset while the slave is holding ACCESS with pready low.
  task automatic reset_mid_access();
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_addr = BASE | 32'h10;
    pready   = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      #1;
      if (psel && penable) seen = 1'b1;
      else @(negedge clk);
    end
    chk1("rst_reached_access", seen, 1'b1);
    rst     = 1'b1;
    mem_req = 1'b0;
    @(negedge clk);
    #1;
    chk1("rst_psel", psel, 1'b0);
    chk1("rst_penable", penable, 1'b0);
    chk1("rst_stall", uart_stall, 1'b0);
    chk("rst_state_idle", 32'(dbg_state), 32'd0);
    chk("rst_paddr", paddr, 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    rst = 1'b0;
    model_rdata = 32'd0;
  endtask

  initial begin
    logic        we;
    logic [31:0] addr;

    rst       = 1'b1;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    mem_wstrb = 4'd0;
    prdata    = 32'd0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk1("reset_psel", psel, 1'b0);
    chk1("reset_penable", penable, 1'b0);
    chk1("reset_pwrite", pwrite, 1'b0);
    chk("reset_paddr", paddr, 32'd0);
    chk("reset_pwdata", pwdata, 32'd0);
    chk("reset_pstrb", 32'(pstrb), 32'd0);
    chk("reset_rdata", mem_rdata, 32'd0);
    chk1("reset_err", mem_err, 1'b0);
    chk1("reset_stall", uart_stall, 1'b0);
    rst = 1'b0;

    access(1'b0, 32'h4000_0004, 32'h0, 4'h0, 0, 32'h0000_00A5, 1'b0, 1'b0);
    access(1'b1, 32'h4000_0000, 32'h41, 4'b0001, 2, 32'h1234_5678, 1'b0, 1'b1);
    access(1'b0, 32'h0000_1000, 32'h0, 4'h0, 0, 32'hCAFE_0000, 1'b0, 1'b0);
    access(1'b0, 32'h4000_0008, 32'h0, 4'h0, 1, 32'h0BAD_F00D, 1'b1, 1'b0);
    access(1'b1, 32'h4FFF_FFFC, 32'hFFFF_FFFF, 4'b1111, 0, 32'h0, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      we = 1'($urandom_range(1, 0));
      if ($urandom_range(3, 0) != 0) begin
        addr = BASE | (32'($urandom) & ~MASK);
      end else begin
        addr = $urandom;
        if ((addr & MASK) == BASE) addr = addr ^ 32'h8000_0000;
      end
      access(we, addr, $urandom, 4'($urandom), int'($urandom_range(6, 0)), $urandom,
             1'($urandom_range(3, 0) == 0), 1'($urandom_range(1, 0)));
    end

`ifdef APB_TIMEOUT_EN
    access(1'b0, 32'h4000_0020, 32'h0, 4'h0, 50, 32'h1111_2222, 1'b0, 1'b0);
    access(1'b1, 32'h4000_0024, 32'h77, 4'b0011, 50, 32'h0, 1'b0, 1'b0);
`endif

    reset_mid_access();

    @(negedge clk);
    #1;
    chk1("final_err", mem_err, 1'b0);
    chk1("final_stall", uart_stall, 1'b0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute guard so the run always ends on its own.
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
